// File: rtl/serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
// Shared definitions for the bit-serial adder controller: the FSM state
// encoding and the default operand width.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

   // Controller states; encodings are fixed so debug probes stay readable.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Default operand/sum width in bits.
   localparam int DEFAULT_WIDTH = 8;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// Purely combinational 1-bit full adder. The controller instantiates exactly
// one of these and time-shares it over all bit positions.
// Ports:
//   a, b  : operand bits
//   ci    : carry in
//   s     : sum bit
//   co    : carry out
// -----------------------------------------------------------------------------
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder_bit

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial WIDTH-bit adder. On an accepted start the operands and carry-in
// are latched, then one full-adder cell is fed LSB-first for WIDTH cycles with
// a registered carry. The assembled sum, carry-out and signed overflow are
// registered when the last bit completes and held until the next completion.
// Ports:
//   clock    : rising-edge system clock
//   reset    : asynchronous, active-high reset
//   start    : begin an addition (honoured in IDLE or DONE only)
//   a, b     : operands, latched on an accepted start
//   cin      : carry-in, latched on an accepted start
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when sum/cout/overflow become valid
//   sum      : result, held until the next completion
//   cout     : carry out of the MSB
//   overflow : signed overflow (carry into MSB XOR carry out of MSB)
// Build option:
//   ACTIVE_LOW_INPUTS_EN : when defined, a, b, cin and start are inverted at
//                          the input boundary (pins that idle high).
// -----------------------------------------------------------------------------
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   state_t             state;
   state_t             next_state;
   logic [WIDTH-1:0]   a_in;
   logic [WIDTH-1:0]   b_in;
   logic               cin_in;
   logic               start_in;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-2:0]   sum_sr;
   logic [WIDTH-1:0]   sum_next;
   logic               carry;
   logic [CNT_W-1:0]   cnt;
   logic               fa_s;
   logic               fa_co;
   logic               accept;
   logic               last_bit;

   // Input boundary: pins that idle high are flipped here so everything
   // downstream sees active-high values.
`ifdef ACTIVE_LOW_INPUTS_EN
   assign a_in     = ~a;
   assign b_in     = ~b;
   assign cin_in   = ~cin;
   assign start_in = ~start;
`else
   assign a_in     = a;
   assign b_in     = b;
   assign cin_in   = cin;
   assign start_in = start;
`endif

   // The single shared adder cell always looks at the LSBs of the operand
   // shift registers and the registered carry.
   full_adder_bit u_cell (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // A start is only honoured outside RUN, so DONE can chain straight into
   // the next operation.
   assign accept   = start_in && (state != ST_RUN);
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // Partial sum fills from the top; after WIDTH shifts the first bit has
   // reached position 0, so the new bit plus the partial is the full word.
   assign sum_next = {fa_s, sum_sr};

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: RUN lasts exactly WIDTH cycles, DONE exactly one.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (accept) next_state = ST_RUN;
         ST_RUN:  if (last_bit) next_state = ST_DONE;
         ST_DONE: next_state = accept ? ST_RUN : ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Datapath: latch on accept, shift one bit per RUN cycle, and publish the
   // result only on the final bit so outputs never show partial sums.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_sr     <= '0;
         b_sr     <= '0;
         sum_sr   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_sr  <= a_in;
         b_sr  <= b_in;
         carry <= cin_in;
         cnt   <= '0;
      end else if (state == ST_RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         sum_sr <= sum_next[WIDTH-1:1];
         carry  <= fa_co;
         cnt    <= cnt + CNT_W'(1);
         if (last_bit) begin
            sum      <= sum_next;
            cout     <= fa_co;
            overflow <= carry ^ fa_co;
         end
      end
   end

   // Status flags decode directly from the state, so they can never overlap.
   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

endmodule : serial_adder_ctrl

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder controller that time-shares a single 1-bit full-adder cell over WIDTH cycles.
- Accepts two operands and a carry-in on a start handshake, then feeds the cell LSB-first with a registered carry.
- Assembles the sum and reports carry-out and signed overflow.
- Sits between the board switch/pin input stage and the LED/display output stage.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; latched on an accepted start.
- b  input  WIDTH  operand B; latched on an accepted start.
- cin  input  1  carry-in; latched on an accepted start.
- busy  output  1  high while the addition is in progress (RUN).
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held until the next completion.
- cout  output  1  carry out of the MSB.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE;
  - busy=0, done=0, sum=0, cout=0, overflow=0;
  - shift registers and bit counter cleared.
  - Reset asserted mid-RUN aborts the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge latches a, b, cin into a_sr, b_sr, carry; clears cnt; goes to RUN.
  - RUN: each cycle the cell evaluates a_sr[0], b_sr[0], carry.
    - Sum bit shifts into sum_sr MSB; a_sr/b_sr shift right; carry <= cell cout; cnt++.
    - At cnt==WIDTH-1 the final bit is processed and state goes to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE.
    - start=1 in DONE is accepted exactly as in IDLE, going directly to RUN (back-to-back operation).
- Timing: start accepted at edge k -> busy=1 for cycles k+1..k+WIDTH -> done=1 in cycle k+WIDTH+1.
  - Latency is WIDTH+1 cycles; throughput is one add per WIDTH+1 cycles.
- sum, cout, overflow are registered on the RUN->DONE edge and hold until the next RUN->DONE edge.
  - They never show partial results.
- overflow = carry entering the MSB XOR final cout (carry register value before/after the last RUN cycle).
- start during RUN is ignored; operand changes during RUN have no effect.
- busy and done are never high simultaneously.
- start held high continuously gives repeated adds on the operands present at each accept edge.

Optional Feature:
- Macro ACTIVE_LOW_INPUTS_EN.
- Defined: a, b, cin and start are inverted at the input boundary before any use.
  - Intended for switches/pins that idle high.
  - Pins all high = start deasserted, operands 0.
- Undefined: all inputs are active-high, used as-is.
- Outputs are unaffected in both builds.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default WIDTH constant.
- One sub-module, full_adder_bit: purely combinational, 1-bit a, b, ci -> s, co.
  - Instantiated once; this is the time-shared resource.
- Counter, shift registers and FSM stay in serial_adder_ctrl.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse -> busy 8 cycles, done at cycle 9, sum=0x8D, cout=0, overflow=1.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, overflow=1.
3. Start pulse, then start=1 and new operands during RUN cycles 2-5 -> ignored; result matches the first operands; exactly one done.
4. start held high across two operations (0x01+0x02 then 0x10+0x20) -> second accepted in the DONE cycle; done pulses 9 cycles apart; sums 0x03 then 0x30.
5. reset asserted mid-RUN (cycle 4), released -> busy=0, done=0, sum=0 immediately; next start gives a correct result.
6. ACTIVE_LOW_INPUTS_EN build: drive inverted pins ~0x05, ~0x03, cin pin=1, start pin low one cycle -> sum=0x08, cout=0.
